// File: rtl/ch4_ctrl.sv
// Noise channel (ch4) register file, frame-step/length sequencing and trigger pulse generation.
// Latency: register writes, triggers and frame ticks take effect one clock later (two on a write/tick collision).
// Backpressure: none; every write is accepted, and a tick that collides with a write is held pending for one cycle.
//
// Ports:
//   dova_phi, apu_reset       : clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data     : CPU write to FF20..FF23 (0=NR41, 1=NR42, 2=NR43, 3=NR44)
//   rd_addr/rd_data           : combinational register readback
//   frame_tick                : 512 Hz frame-sequencer strobe
//   nr42, nr43                : envelope / LFSR configuration to the datapath
//   ch4_restart, env_tick     : trigger pulse (RESTART_LEN clocks) and 64 Hz envelope step
//   ch4_active, nch4_amp_en   : channel status bit and DAC-off indication
module ch4_ctrl #(
    parameter int unsigned RESTART_LEN = 4
) (
    input  logic       dova_phi,
    input  logic       apu_reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       frame_tick,
    output logic [7:0] nr42,
    output logic [7:0] nr43,
    output logic       ch4_restart,
    output logic       env_tick,
    output logic       ch4_active,
    output logic       nch4_amp_en
);

    localparam logic [3:0] RESTART_CNT = 4'(RESTART_LEN);

    logic       len_en;
    logic [2:0] step;
    logic [6:0] len;
    logic       tick_pend;
    logic [3:0] rst_cnt;

    logic [7:0] nr42_n;
    logic [7:0] nr43_n;
    logic       len_en_n;
    logic [2:0] step_n;
    logic [6:0] len_n;
    logic       tick_pend_n;
    logic [3:0] rst_cnt_n;
    logic       active_n;
    logic       env_tick_n;
    logic       do_tick;
    logic       extra_clk;

    always_comb begin
        nr42_n      = nr42;
        nr43_n      = nr43;
        len_en_n    = len_en;
        step_n      = step;
        len_n       = len;
        active_n    = ch4_active;
        env_tick_n  = 1'b0;
        extra_clk   = 1'b0;
        // A tick arriving with a write is deferred by exactly one cycle.
        tick_pend_n = frame_tick & wr_en;
        do_tick     = tick_pend | (frame_tick & ~wr_en);
        rst_cnt_n   = (rst_cnt != 4'd0) ? rst_cnt - 4'd1 : 4'd0;

        // Frame step first, so a write landing on the same edge sees the
        // post-tick step/length and can override them.
        if (do_tick) begin
            if (step == 3'd7) begin
                env_tick_n = 1'b1;
            end
            if (!step[0] && len_en && (len != 7'd0)) begin
                len_n = len - 7'd1;
                if (len == 7'd1) begin
                    active_n = 1'b0;
                end
            end
            step_n = step + 3'd1;
        end

        if (wr_en) begin
            case (wr_addr)
                2'd0: len_n = 7'd64 - {1'b0, wr_data[5:0]};
                2'd1: begin
                    nr42_n = wr_data;
                    if (wr_data[7:3] == 5'd0) begin
                        active_n = 1'b0;
                    end
                end
                2'd2: nr43_n = wr_data;
                default: begin
                    len_en_n = wr_data[6];
                    // Enabling length right after a step that clocked length
                    // (odd step) gets one immediate extra length clock.
                    extra_clk = ~len_en & wr_data[6] & step_n[0] & (len_n != 7'd0);
                    if (extra_clk) begin
                        len_n = len_n - 7'd1;
                        if ((len_n == 7'd0) && !wr_data[7]) begin
                            active_n = 1'b0;
                        end
                    end
                    if (wr_data[7]) begin
                        if (len_n == 7'd0) begin
                            len_n = extra_clk ? 7'd63 : 7'd64;
                        end
                        active_n  = (nr42[7:3] != 5'd0);
                        rst_cnt_n = RESTART_CNT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge dova_phi) begin
        if (apu_reset) begin
            nr42        <= 8'd0;
            nr43        <= 8'd0;
            len_en      <= 1'b0;
            step        <= 3'd0;
            len         <= 7'd0;
            tick_pend   <= 1'b0;
            rst_cnt     <= 4'd0;
            ch4_active  <= 1'b0;
            ch4_restart <= 1'b0;
            env_tick    <= 1'b0;
        end else begin
            nr42        <= nr42_n;
            nr43        <= nr43_n;
            len_en      <= len_en_n;
            step        <= step_n;
            len         <= len_n;
            tick_pend   <= tick_pend_n;
            rst_cnt     <= rst_cnt_n;
            ch4_active  <= active_n;
            ch4_restart <= (rst_cnt_n != 4'd0);
            env_tick    <= env_tick_n;
        end
    end

    assign nch4_amp_en = (nr42[7:3] == 5'd0);

    always_comb begin
        case (rd_addr)
            2'd0:    rd_data = 8'hFF;
            2'd1:    rd_data = nr42;
            2'd2:    rd_data = nr43;
            default: rd_data = {1'b1, len_en, 6'h3F};
        endcase
    end

endmodule
